// File: rtl/ysyx_24110015_trap_ctrl.sv
// =============================================================================
// Module   : ysyx_24110015_trap_ctrl
// Brief    : Trap/mret sequencer driving the M-mode CSR write ports and a
//            redirect PC to fetch. Optional trap counter: YSYX_24110015_TRAP_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ysyx_24110015_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [1:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic [XLEN-1:0] din_mstatus,
  output logic [XLEN-1:0] din_mepc,
  output logic [XLEN-1:0] din_mcause,
  output logic            wen_mstatus,
  output logic            wen_mepc,
  output logic            wen_mcause,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
`ifdef YSYX_24110015_TRAP_CNT_EN
  ,
  output logic [XLEN-1:0] trap_count
`endif
);

  localparam logic [1:0] c_kind_ecall  = 2'b00;
  localparam logic [1:0] c_kind_ebreak = 2'b01;
  localparam logic [1:0] c_kind_exc    = 2'b10;
  localparam logic [1:0] c_kind_mret   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    STATUS   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              is_mret_q, is_mret_d;
  logic              accept;
  logic [XLEN-1:0]   mstatus_upd;
  logic              unused_mtvec_lo;

  // mtvec MODE bits are discarded: the target is always the direct base.
  assign unused_mtvec_lo = ^mtvec_in[1:0];

  assign accept = trap_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    target_d  = target_q;
    is_mret_d = is_mret_q;
    case (state_q)
      IDLE: begin
        if (trap_valid) begin
          epc_d     = trap_pc;
          is_mret_d = (trap_kind == c_kind_mret);
          case (trap_kind)
            c_kind_ecall:  cause_d = {{(XLEN-4){1'b0}}, 4'd11};
            c_kind_ebreak: cause_d = {{(XLEN-4){1'b0}}, 4'd3};
            c_kind_exc:    cause_d = trap_cause;
            default:       cause_d = '0;
          endcase
          if (trap_kind == c_kind_mret) begin
            target_d = mepc_in;
            state_d  = STATUS;
          end else begin
            target_d = {mtvec_in[XLEN-1:2], 2'b00};
            state_d  = SAVE;
          end
        end
      end
      SAVE:     state_d = STATUS;
      STATUS:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      target_q  <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      target_q  <= target_d;
      is_mret_q <= is_mret_d;
    end
  end

  // MPP is forced to M on both paths since this core has no lower privilege.
  always_comb begin
    mstatus_upd = mstatus_in;
    if (is_mret_q) begin
      mstatus_upd[3] = mstatus_in[7];
      mstatus_upd[7] = 1'b1;
    end else begin
      mstatus_upd[7] = mstatus_in[3];
      mstatus_upd[3] = 1'b0;
    end
    mstatus_upd[12:11] = 2'b11;
  end

  always_comb begin
    trap_ready     = (state_q == IDLE);
    busy           = (state_q != IDLE);
    wen_mepc       = (state_q == SAVE);
    wen_mcause     = (state_q == SAVE);
    wen_mstatus    = (state_q == STATUS);
    redirect_valid = (state_q == REDIRECT);
    din_mepc       = wen_mepc       ? epc_q       : '0;
    din_mcause     = wen_mcause     ? cause_q     : '0;
    din_mstatus    = wen_mstatus    ? mstatus_upd : '0;
    redirect_pc    = redirect_valid ? target_q    : '0;
  end

`ifdef YSYX_24110015_TRAP_CNT_EN
  logic [XLEN-1:0] trap_cnt_q, trap_cnt_d;

  always_comb begin
    trap_cnt_d = trap_cnt_q;
    if (accept && (trap_kind != c_kind_mret))
      trap_cnt_d = trap_cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap_cnt_q <= '0;
    else      trap_cnt_q <= trap_cnt_d;
  end

  assign trap_count = trap_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24110015_trap_ctrl.sv
// =============================================================================
// Module   : tb_ysyx_24110015_trap_ctrl
// Brief    : Self-checking bench for ysyx_24110015_trap_ctrl with a transaction
//            level reference model (queue of expected phases per request).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ysyx_24110015_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tv;
  logic [1:0]  kind;
  logic [31:0] tpc, tcause, ms, mt, me;
  logic        rr;

  logic        trap_ready, wen_mstatus, wen_mepc, wen_mcause, redirect_valid, busy;
  logic [31:0] din_mstatus, din_mepc, din_mcause, redirect_pc;
`ifdef YSYX_24110015_TRAP_CNT_EN
  logic [31:0] trap_count;
`endif

  always #5 clk = ~clk;

  ysyx_24110015_trap_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid     (tv),
    .trap_ready     (trap_ready),
    .trap_kind      (kind),
    .trap_pc        (tpc),
    .trap_cause     (tcause),
    .mstatus_in     (ms),
    .mtvec_in       (mt),
    .mepc_in        (me),
    .din_mstatus    (din_mstatus),
    .din_mepc       (din_mepc),
    .din_mcause     (din_mcause),
    .wen_mstatus    (wen_mstatus),
    .wen_mepc       (wen_mepc),
    .wen_mcause     (wen_mcause),
    .redirect_valid (redirect_valid),
    .redirect_ready (rr),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef YSYX_24110015_TRAP_CNT_EN
    ,
    .trap_count     (trap_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_wm = 0, n_wc = 0, n_ws = 0, n_rv = 0;

  // One entry per cycle the request will occupy: 1 = CSR save, 2 = status, 3 = redirect.
  typedef struct {
    int          ph;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] target;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] mstatus_after(input logic [31:0] m, input logic mret);
    logic [31:0] base;
    base = (m & ~32'h0000_1888) | 32'h0000_1800;
    if (mret) return base | (((m >> 7) & 32'h1) << 3) | 32'h0000_0080;
    else      return base | (((m >> 3) & 32'h1) << 7);
  endfunction

  // Reference model: advances on the same edge as the DUT, reset is asynchronous.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
    end else if (mq.size() == 0) begin
      if (tv) begin
        rec_t r;
        r.mret   = (kind == 2'b11);
        r.epc    = tpc;
        r.cause  = (kind == 2'b00) ? 32'd11 : (kind == 2'b01) ? 32'd3 : tcause;
        r.target = r.mret ? me : (mt & ~32'h3);
        if (!r.mret) begin
          r.ph = 1;
          mq.push_back(r);
          m_cnt = m_cnt + 1;
        end
        r.ph = 2; mq.push_back(r);
        r.ph = 3; mq.push_back(r);
      end
    end else if (mq[0].ph != 3 || rr) begin
      void'(mq.pop_front());
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    rec_t r;
    int   ph;
    #1;
    ph = 0;
    r  = '{0, 1'b0, 32'h0, 32'h0, 32'h0};
    if (mq.size() != 0) begin
      r  = mq[0];
      ph = r.ph;
    end
    chkb("trap_ready", trap_ready, ph == 0);
    chkb("busy", busy, ph != 0);
    chkb("wen_mepc", wen_mepc, ph == 1);
    chkb("wen_mcause", wen_mcause, ph == 1);
    chk ("din_mepc", din_mepc, (ph == 1) ? r.epc : 32'h0);
    chk ("din_mcause", din_mcause, (ph == 1) ? r.cause : 32'h0);
    chkb("wen_mstatus", wen_mstatus, ph == 2);
    chk ("din_mstatus", din_mstatus, (ph == 2) ? mstatus_after(ms, r.mret) : 32'h0);
    chkb("redirect_valid", redirect_valid, ph == 3);
    chk ("redirect_pc", redirect_pc, (ph == 3) ? r.target : 32'h0);
`ifdef YSYX_24110015_TRAP_CNT_EN
    chk ("trap_count", trap_count, m_cnt);
`endif
    if (wen_mepc)       n_wm++;
    if (wen_mcause)     n_wc++;
    if (wen_mstatus)    n_ws++;
    if (redirect_valid) n_rv++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (trap_ready) break;
      @(negedge clk);
    end
    chkb("wait_idle", trap_ready, 1'b1);
  endtask

  task automatic req(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] c);
    step(); tv = 1'b1; kind = k; tpc = pc; tcause = c; rr = 1'b1;
    step(); tv = 1'b0;
    wait_idle(10);
  endtask

  initial begin
    rst = 1'b0; tv = 1'b0; kind = 2'b00; rr = 1'b0;
    tpc = 32'h0; tcause = 32'h0; ms = 32'h0; mt = 32'h0; me = 32'h0;
    repeat (2) step();
    #1;
    chkb("rst_trap_ready", trap_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chk ("rst_redirect_pc", redirect_pc, 32'h0);
    step(); rst = 1'b1;

    // ecall
    step(); tv = 1'b1; kind = 2'b00; tpc = 32'h8000_0010; mt = 32'h8000_0103;
    ms = 32'h0000_1808; rr = 1'b1;
    step(); tv = 1'b0; #1;
    chk("ecall_mepc", din_mepc, 32'h8000_0010);
    chk("ecall_mcause", din_mcause, 32'd11);
    step(); #1;
    chk("ecall_mstatus", din_mstatus, 32'h0000_1880);
    step(); #1;
    chk("ecall_redirect_pc", redirect_pc, 32'h8000_0100);
    step(); #1;
    chkb("ecall_ready_again", trap_ready, 1'b1);

    // mret
    step(); tv = 1'b1; kind = 2'b11; me = 32'h8000_0014; ms = 32'h0000_1880;
    n_wm = 0; n_wc = 0;
    step(); tv = 1'b0; #1;
    chkb("mret_wen_mstatus", wen_mstatus, 1'b1);
    chk ("mret_mstatus", din_mstatus, 32'h0000_1888);
    step(); #1;
    chk ("mret_redirect_pc", redirect_pc, 32'h8000_0014);
    step(); #1;
    chk ("mret_no_mepc", n_wm, 0);
    chk ("mret_no_mcause", n_wc, 0);

    // exception and ebreak causes
    step(); tv = 1'b1; kind = 2'b10; tcause = 32'd2; tpc = 32'h8000_0020;
    step(); tv = 1'b0; #1;
    chk("exc_mcause", din_mcause, 32'd2);
    wait_idle(10);
    step(); tv = 1'b1; kind = 2'b01; tpc = 32'h8000_0024;
    step(); tv = 1'b0; #1;
    chk("ebreak_mcause", din_mcause, 32'd3);
    wait_idle(10);

    // redirect backpressure with the next request already waiting
    step(); tv = 1'b1; kind = 2'b00; tpc = 32'h8000_0030; mt = 32'h0000_0201; rr = 1'b0;
    n_wm = 0; n_wc = 0; n_ws = 0;
    step(); #1; chkb("bp_save_not_ready", trap_ready, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chkb("bp_valid_held", redirect_valid, 1'b1);
      chk ("bp_pc_held", redirect_pc, 32'h0000_0200);
    end
    step(); rr = 1'b1; #1;
    chkb("bp_handshake_not_ready", trap_ready, 1'b0);
    step(); rr = 1'b0; #1;
    chkb("bp_idle_after_handshake", trap_ready, 1'b1);
    chk ("bp_one_mepc", n_wm, 1);
    chk ("bp_one_mcause", n_wc, 1);
    chk ("bp_one_mstatus", n_ws, 1);
    step(); tv = 1'b0; rr = 1'b1; #1;
    chkb("bp_second_accepted", busy, 1'b1);
    wait_idle(10);

    // reset during SAVE
    step(); tv = 1'b1; kind = 2'b00; tpc = 32'h8000_0040; rr = 1'b1;
    n_ws = 0; n_rv = 0;
    step(); tv = 1'b0; #1;
    chkb("rstmid_in_save", wen_mepc, 1'b1);
    #1; rst = 1'b0; #1;
    chkb("rstmid_ready", trap_ready, 1'b1);
    chkb("rstmid_wen_mepc", wen_mepc, 1'b0);
    step(); step(); rst = 1'b1;
    repeat (4) step();
    #1;
    chk("rstmid_no_mstatus", n_ws, 0);
    chk("rstmid_no_redirect", n_rv, 0);

`ifdef YSYX_24110015_TRAP_CNT_EN
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    req(2'b00, 32'h100, 32'h0);
    req(2'b00, 32'h104, 32'h0);
    req(2'b00, 32'h108, 32'h0);
    req(2'b11, 32'h10c, 32'h0);
    chk("cnt_three", trap_count, 32'd3);
    step(); #2;
    force dut.trap_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.trap_cnt_q;
    step(); #1;
    chk("cnt_preload", trap_count, 32'hFFFF_FFFF);
    req(2'b00, 32'h110, 32'h0);
    chk("cnt_wrap", trap_count, 32'h0);
`endif

    // randomized traffic including occasional resets
    for (int i = 0; i < 800; i++) begin
      step();
      rst    = ($urandom_range(99) != 0);
      tv     = ($urandom_range(2) == 0);
      kind   = 2'($urandom_range(3));
      tpc    = $urandom;
      tcause = $urandom;
      ms     = $urandom;
      mt     = $urandom;
      me     = $urandom;
      rr     = ($urandom_range(1) == 1);
    end
    step(); rst = 1'b1; tv = 1'b0; rr = 1'b1;
    wait_idle(10);
    step(); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_24110015_trap_ctrl.md
# ysyx_24110015_trap_ctrl

Trap sequencer sitting directly upstream of the machine-mode CSR file. It accepts ecall/ebreak/exception/mret requests from the execute stage and drives the CSR file's write ports (`mepc`, `mcause`, `mstatus`) in a fixed multi-cycle sequence. It reads current CSR values back from the CSR file's outputs, then hands a redirect PC to instruction fetch over a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, data and address width; only 32 is supported.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `trap_valid`  input  1  trap request from execute.
- `trap_ready`  output  1  high only in IDLE; request accepted on `trap_valid && trap_ready`.
- `trap_kind`  input  2  request kind: 00 ecall, 01 ebreak, 10 exception, 11 mret.
- `trap_pc`  input  32  PC of the trapping instruction.
- `trap_cause`  input  32  cause code; used only for kind 10.
- `mstatus_in`, `mtvec_in`, `mepc_in`  input  32 each  current CSR values from the CSR file outputs.
- `din_mstatus`, `din_mepc`, `din_mcause`  output  32 each  CSR write data.
- `wen_mstatus`, `wen_mepc`, `wen_mcause`  output  1 each  CSR write enables, one-cycle pulses.
- `redirect_valid`  output  1  redirect PC available for fetch.
- `redirect_ready`  input  1  fetch accepts the redirect.
- `redirect_pc`  output  32  target PC.
- `busy`  output  1  state is not IDLE.
- `trap_count`  output  32  present only with `YSYX_24110015_TRAP_CNT_EN`.

## Operation
States: IDLE, SAVE, STATUS, REDIRECT. Moore FSM; enables and valid decode from the state register.

On accept in IDLE, the block latches the following:
- `epc` ← `trap_pc`.
- `cause` ← 11 for ecall, 3 for ebreak, `trap_cause` for exception.
- `is_mret` flag.
- `target` ← `{mtvec_in[31:2],2'b00}` for traps, `mepc_in` for mret.

State transitions:
- IDLE → SAVE for kinds 00/01/10.
- IDLE → STATUS for mret.
- SAVE: `wen_mepc` = `wen_mcause` = 1, `din_mepc` = `epc`, `din_mcause` = `cause`; → STATUS.
- STATUS: `wen_mstatus` = 1, `din_mstatus` derived combinationally from `mstatus_in`, all other bits unchanged; → REDIRECT.
  - Trap: MPIE[7] ← MIE[3], MIE[3] ← 0, MPP[12:11] ← 2'b11.
  - mret: MIE[3] ← MPIE[7], MPIE[7] ← 1, MPP[12:11] ← 2'b11 (M-only core).
- REDIRECT: `redirect_valid` = 1, `redirect_pc` = `target`; → IDLE on `redirect_ready`.

Rules:
- `din_*` outputs are 0 whenever their enable is 0.
- `redirect_pc` reads 0 outside REDIRECT.
- `trap_valid` outside IDLE is ignored; `trap_ready` = 0 there, and the request is not lost if the requester holds valid.
- mret never writes `mepc` or `mcause`.

## Timing
- Reset, asynchronous: state = IDLE, latched registers = 0, `trap_count` = 0.
  - All outputs 0 except `trap_ready` = 1.
- Trap path, accept edge = cycle 0:
  - cycle 1 SAVE (mepc/mcause write at end of cycle 1).
  - cycle 2 STATUS.
  - cycle 3 `redirect_valid` = 1.
  - Minimum 4 cycles from accept to `trap_ready` again.
- mret path: cycle 1 STATUS, cycle 2 REDIRECT; minimum 3 cycles.
- Redirect backpressure:
  - `redirect_valid` and `redirect_pc` are held stable while `redirect_ready` = 0.
  - No CSR write repeats.
- Simultaneous `redirect_ready` and a new `trap_valid`: the new request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- Reset mid-sequence: sequence aborts immediately.
  - No further write pulses.
  - Already-issued CSR writes are not undone.
  - Redirect is dropped.

## Configuration
- `YSYX_24110015_TRAP_CNT_EN` defined:
  - 32-bit `trap_count` increments by 1 on each accepted non-mret request.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0.
- Not defined: `trap_count` port and counter are absent; all other behaviour is identical.

## Test plan
- ecall, `trap_pc` = 0x80000010, `mtvec_in` = 0x80000103, `mstatus_in` = 0x00001808:
  - cycle 1: `din_mepc` = 0x80000010, `din_mcause` = 11.
  - cycle 2: `din_mstatus` = 0x00001880.
  - cycle 3: `redirect_pc` = 0x80000100.
- mret, `mepc_in` = 0x80000014, `mstatus_in` = 0x00001880:
  - no mepc/mcause write.
  - cycle 1: `din_mstatus` = 0x00001888.
  - cycle 2: `redirect_pc` = 0x80000014.
- Exception kind 10, `trap_cause` = 2: `din_mcause` = 2. ebreak: `din_mcause` = 3.
- Hold `redirect_ready` = 0 for 5 cycles in REDIRECT:
  - valid and pc stable.
  - exactly one pulse each of the CSR enables.
  - `trap_valid` held high throughout is accepted only after the handshake.
- Assert `rst` low during SAVE:
  - next edge shows IDLE, `trap_ready` = 1.
  - no `wen_mstatus` pulse.
  - no redirect.
- With `YSYX_24110015_TRAP_CNT_EN`:
  - 3 ecalls + 1 mret → `trap_count` = 3.
  - Preload via reset-free sequence to 0xFFFFFFFF (forced in the bench), one ecall → 0.
